// File: rtl/w0rm_core_ifetch_prefetch_if.sv
// Bundle of the instruction-memory and decode handshakes for the prefetch stage.
// master = fetch core side, slave = memory/decode/execute environment.
interface w0rm_core_ifetch_prefetch_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_req;
    logic                  mem_ready;
    logic [INST_WIDTH-1:0] mem_data;
    logic                  mem_valid;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  decode_ready;
    logic [INST_WIDTH-1:0] inst_data_out;
    logic [DATA_WIDTH-1:0] inst_pc_out;
    logic                  inst_valid_out;
    logic                  ifetch_ready;

    modport master (
        output mem_addr, mem_req, inst_data_out, inst_pc_out, inst_valid_out, ifetch_ready,
        input  mem_ready, mem_data, mem_valid, redirect, redirect_pc, decode_ready
    );

    modport slave (
        input  mem_addr, mem_req, inst_data_out, inst_pc_out, inst_valid_out, ifetch_ready,
        output mem_ready, mem_data, mem_valid, redirect, redirect_pc, decode_ready
    );
endinterface

// File: rtl/w0rm_core_ifetch_prefetch.sv
// Sequential instruction prefetcher with credit-limited issue and redirect flush/squash.
// Optional fetch-starvation counter enabled by the W0RM_IFETCH_STALL_COUNT_EN macro.
module w0rm_core_ifetch_prefetch #(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           INST_WIDTH      = 16,
    parameter logic [DATA_WIDTH-1:0] START_PC        = 32'h2000_0000,
    parameter int unsigned           FIFO_DEPTH      = 4,
    parameter int unsigned           MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef W0RM_IFETCH_STALL_COUNT_EN
    output logic [31:0] stall_count,
`endif
    w0rm_core_ifetch_prefetch_if.master bus
);
    localparam int unsigned           AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned           CW     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned           OW     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [DATA_WIDTH-1:0] PC_INC = DATA_WIDTH'(INST_WIDTH / 8);

    logic [DATA_WIDTH-1:0] fetch_pc_r;
    logic [DATA_WIDTH-1:0] resp_pc_r;
    logic [CW-1:0]         fifo_count_r;
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [OW-1:0]         outstanding_r;
    logic [OW-1:0]         squash_r;
    logic                  run_r;
    logic [INST_WIDTH-1:0] fifo_data_r [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc_r   [FIFO_DEPTH];

    logic [31:0] occupancy_s;
    logic        credit_s;
    logic        mem_req_s;
    logic        req_xfer_s;
    logic        resp_s;
    logic        drop_s;
    logic        push_s;
    logic        pop_s;

    // Issue credit and per-cycle transfer events; squashed slots still hold a reservation until they return.
    always_comb begin
        occupancy_s = 32'(fifo_count_r) + 32'(outstanding_r) - 32'(squash_r);
        if ((32'(outstanding_r) < MAX_OUTSTANDING) && (occupancy_s < FIFO_DEPTH)) begin
            credit_s = 1'b1;
        end else begin
            credit_s = 1'b0;
        end
        mem_req_s  = run_r & ~bus.redirect & credit_s;
        req_xfer_s = mem_req_s & bus.mem_ready;
        resp_s     = bus.mem_valid & (outstanding_r != OW'(0));
        drop_s     = resp_s & (squash_r != OW'(0));
        push_s     = resp_s & ~drop_s & ~bus.redirect;
        pop_s      = (fifo_count_r != CW'(0)) & bus.decode_ready;
    end

    assign bus.mem_req        = mem_req_s;
    assign bus.mem_addr       = fetch_pc_r;
    assign bus.inst_valid_out = (fifo_count_r != CW'(0));
    assign bus.inst_data_out  = fifo_data_r[rd_ptr_r];
    assign bus.inst_pc_out    = fifo_pc_r[rd_ptr_r];
    assign bus.ifetch_ready   = run_r & ~bus.redirect;

    // Fetch/response PCs, FIFO pointers and the outstanding/squash bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r    <= START_PC;
            resp_pc_r     <= START_PC;
            fifo_count_r  <= CW'(0);
            wr_ptr_r      <= AW'(0);
            rd_ptr_r      <= AW'(0);
            outstanding_r <= OW'(0);
            squash_r      <= OW'(0);
            run_r         <= 1'b0;
        end else if (bus.redirect) begin
            run_r         <= 1'b1;
            fetch_pc_r    <= bus.redirect_pc;
            resp_pc_r     <= bus.redirect_pc;
            fifo_count_r  <= CW'(0);
            wr_ptr_r      <= AW'(0);
            rd_ptr_r      <= AW'(0);
            outstanding_r <= outstanding_r - OW'(resp_s);
            squash_r      <= outstanding_r - OW'(resp_s);
        end else begin
            run_r <= 1'b1;
            if (req_xfer_s) begin
                fetch_pc_r <= fetch_pc_r + PC_INC;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
            if (push_s) begin
                resp_pc_r <= resp_pc_r + PC_INC;
                wr_ptr_r  <= wr_ptr_r + AW'(1'b1);
            end else begin
                resp_pc_r <= resp_pc_r;
                wr_ptr_r  <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CW'(1'b1);
                2'b01:   fifo_count_r <= fifo_count_r - CW'(1'b1);
                default: fifo_count_r <= fifo_count_r;
            endcase
            case ({req_xfer_s, resp_s})
                2'b10:   outstanding_r <= outstanding_r + OW'(1'b1);
                2'b01:   outstanding_r <= outstanding_r - OW'(1'b1);
                default: outstanding_r <= outstanding_r;
            endcase
            if (drop_s) begin
                squash_r <= squash_r - OW'(1'b1);
            end else begin
                squash_r <= squash_r;
            end
        end
    end

    // Prefetch storage; contents are only meaningful under a valid count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_data_r[wr_ptr_r] <= bus.mem_data;
            fifo_pc_r[wr_ptr_r]   <= resp_pc_r;
        end
    end

`ifdef W0RM_IFETCH_STALL_COUNT_EN
    logic [31:0] stall_count_r;

    // Saturating count of cycles where decode waits on an empty prefetch buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_r <= 32'd0;
        end else if (bus.decode_ready && (fifo_count_r == CW'(0)) && (stall_count_r != 32'hFFFF_FFFF)) begin
            stall_count_r <= stall_count_r + 32'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;
`endif

    // A response with nothing outstanding is a memory protocol violation; the RTL ignores it.
    a_no_orphan_response: assert property (@(posedge clk) disable iff (!reset_n)
        bus.mem_valid |-> (outstanding_r != OW'(0)));

endmodule

// File: tb/tb_w0rm_core_ifetch_prefetch.sv
// Randomised bench for the prefetch stage: memory/decode/redirect driver plus a
// scoreboard monitor built from a stream-level model of fetch order and redirects.
module tb_w0rm_core_ifetch_prefetch;
    localparam int unsigned DW    = 32;
    localparam int unsigned IW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 2;
    localparam logic [31:0] START = 32'h2000_0000;
    localparam logic [31:0] INC   = 32'd2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
`ifdef W0RM_IFETCH_STALL_COUNT_EN
    logic [31:0] stall_count;
`endif

    w0rm_core_ifetch_prefetch_if #(.DATA_WIDTH(DW), .INST_WIDTH(IW)) bus ();

    w0rm_core_ifetch_prefetch #(
        .DATA_WIDTH(DW), .INST_WIDTH(IW), .START_PC(START),
        .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef W0RM_IFETCH_STALL_COUNT_EN
        .stall_count(stall_count),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic [15:0] data; } entry_t;
    typedef struct packed { logic [31:0] epoch; logic [31:0] addr; } req_t;

    entry_t      exp_q [$];
    req_t        out_q [$];
    logic [31:0] mem_q [$];

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned pop_cnt = 0;

    int unsigned p_ready = 100, p_resp = 100, p_dec = 100, p_redir = 0;
    logic        force_redir = 1'b0;
    logic [31:0] force_pc = 32'd0;

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[16:1] ^ a[31:16] ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Driver: one cycle of memory, decode and redirect stimulus, applied just after the edge.
    task automatic step();
        logic [31:0] a;
        logic [31:0] t;
        @(posedge clk); #1;
        bus.mem_ready    = ($urandom_range(0, 99) < p_ready);
        bus.decode_ready = ($urandom_range(0, 99) < p_dec);
        if (mem_q.size() > 0 && $urandom_range(0, 99) < p_resp) begin
            a = mem_q.pop_front();
            bus.mem_valid = 1'b1;
            bus.mem_data  = mem_word(a);
        end else begin
            bus.mem_valid = 1'b0;
            bus.mem_data  = 16'($urandom());
        end
        if (force_redir) begin
            bus.redirect    = 1'b1;
            bus.redirect_pc = force_pc;
            force_redir     = 1'b0;
        end else if ($urandom_range(0, 99) < p_redir) begin
            case ($urandom_range(0, 2))
                0:       t = 32'hFFFF_FFFC;
                1:       t = 32'h2000_0100;
                default: t = $urandom() & 32'hFFFF_FFFE;
            endcase
            bus.redirect    = 1'b1;
            bus.redirect_pc = t;
        end else begin
            bus.redirect    = 1'b0;
            bus.redirect_pc = $urandom();
        end
    endtask

    task automatic do_reset(input int unsigned n);
        @(posedge clk); #1;
        reset_n          = 1'b0;
        mem_q.delete();
        bus.mem_valid    = 1'b0;
        bus.mem_data     = 16'd0;
        bus.mem_ready    = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = 32'd0;
        bus.decode_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Monitor/scoreboard state
    logic [31:0] next_pc, epoch, hold_addr, redir_target, last_acc;
    logic        hold_valid, first_cycle, first_after_redir, saw_wrap;
    logic [31:0] stall_model;
    entry_t      e;
    req_t        r;

    initial saw_wrap = 1'b0;

    // Monitor: samples mid-cycle, checks outputs against the model, then advances the model.
    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_mem_req", 32'(bus.mem_req), 32'd0);
            check("rst_inst_valid", 32'(bus.inst_valid_out), 32'd0);
            check("rst_ifetch_ready", 32'(bus.ifetch_ready), 32'd0);
`ifdef W0RM_IFETCH_STALL_COUNT_EN
            check("rst_stall_count", stall_count, 32'd0);
`endif
            exp_q.delete();
            out_q.delete();
            next_pc           = START;
            epoch             = 32'd0;
            hold_valid        = 1'b0;
            first_cycle       = 1'b1;
            first_after_redir = 1'b0;
            stall_model       = 32'd0;
            last_acc          = 32'd0;
        end else begin
            check("inst_valid", 32'(bus.inst_valid_out), 32'(exp_q.size() != 0));
            check("ifetch_ready", 32'(bus.ifetch_ready), 32'(!first_cycle && !bus.redirect));
`ifdef W0RM_IFETCH_STALL_COUNT_EN
            check("stall_count", stall_count, stall_model);
`endif
            if (bus.redirect) check("redir_no_req", 32'(bus.mem_req), 32'd0);
            if (hold_valid) check("addr_hold", bus.mem_addr, hold_addr);

            if (bus.inst_valid_out && bus.decode_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", bus.inst_pc_out, e.pc);
                    check("pop_data", 32'(bus.inst_data_out), 32'(e.data));
                    if (first_after_redir) begin
                        check("redir_first_pc", bus.inst_pc_out, redir_target);
                        first_after_redir = 1'b0;
                    end
                end
            end
            if (bus.mem_req && bus.mem_ready) begin
                check("req_addr", bus.mem_addr, next_pc);
                if (bus.mem_addr == 32'd0 && last_acc == 32'hFFFF_FFFE) saw_wrap = 1'b1;
                last_acc = bus.mem_addr;
                next_pc  = next_pc + INC;
                r.epoch  = epoch;
                r.addr   = bus.mem_addr;
                out_q.push_back(r);
                mem_q.push_back(bus.mem_addr);
            end
            if (bus.mem_valid) begin
                if (out_q.size() == 0) begin
                    check("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    r = out_q.pop_front();
                    if (!bus.redirect && r.epoch == epoch) begin
                        e.pc   = r.addr;
                        e.data = mem_word(r.addr);
                        exp_q.push_back(e);
                    end
                end
            end
            if (bus.redirect) begin
                exp_q.delete();
                epoch             = epoch + 32'd1;
                next_pc           = bus.redirect_pc;
                redir_target      = bus.redirect_pc;
                first_after_redir = 1'b1;
            end
            check("fifo_bound", 32'(exp_q.size() <= DEPTH), 32'd1);
            check("outstanding_bound", 32'(out_q.size() <= MAXO), 32'd1);
            if (bus.decode_ready && !bus.inst_valid_out && stall_model != 32'hFFFF_FFFF)
                stall_model = stall_model + 32'd1;
            hold_valid  = bus.mem_req && !bus.mem_ready;
            hold_addr   = bus.mem_addr;
            first_cycle = 1'b0;
        end
    end

    int unsigned pops0;
    logic [31:0] addr0;

    initial begin
        do_reset(3);

        // Zero-wait memory, decode always ready: 1 instruction per cycle after warm-up.
        p_ready = 100; p_resp = 100; p_dec = 100; p_redir = 0;
        repeat (8) step();
        pops0 = pop_cnt;
        repeat (10) step();
        check("throughput", pop_cnt - pops0, 32'd10);

        // Decode stalled: buffer fills to depth, requests stop.
        p_dec = 0;
        repeat (12) step();
        check("bp_entries", 32'(exp_q.size()), 32'(DEPTH));
        check("bp_outstanding", 32'(out_q.size()), 32'd0);
        check("bp_mem_req", 32'(bus.mem_req), 32'd0);
        check("bp_valid", 32'(bus.inst_valid_out), 32'd1);
        p_dec = 100;
        repeat (8) step();

        // Two requests in flight, then redirect: both old responses must vanish.
        p_resp = 0;
        repeat (6) step();
        check("two_outstanding", 32'(out_q.size()), 32'd2);
        force_redir = 1'b1; force_pc = 32'h2000_0100;
        step();
        p_resp = 100;
        repeat (10) step();

        // Memory not ready for 3 cycles: address held, single transfer on accept.
        p_ready = 0;
        step();
        addr0 = bus.mem_addr;
        repeat (3) step();
        check("stall_addr", bus.mem_addr, addr0);
        p_ready = 100;
        repeat (6) step();

        // PC wrap at the top of the address space.
        force_redir = 1'b1; force_pc = 32'hFFFF_FFFE;
        step();
        repeat (8) step();
        check("wrap_seen", 32'(saw_wrap), 32'd1);

        // Starved decode right after reset.
        do_reset(2);
        p_resp = 0; p_dec = 100; p_ready = 100;
        repeat (5) step();
        p_resp = 100;
        repeat (6) step();

        // Randomised traffic with redirects and a mid-run reset.
        p_ready = 70; p_resp = 60; p_dec = 60; p_redir = 5;
        repeat (1500) step();
        do_reset(2);
        repeat (1500) step();
        p_redir = 0; p_resp = 100; p_dec = 100;
        repeat (20) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
